// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider sequencer.
//   state_t       : sequencer FSM states
//   DEFAULT_RATIO : ratio loaded into every stage at reset
//   r_eff()       : effective divide ratio (0 behaves as 1)
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEFAULT_RATIO = 2;

  function automatic int r_eff(input int ratio);
    return (ratio == 0) ? 1 : ratio;
  endfunction

endpackage

// File: rtl/clk_div_stage.sv
// One divider stage: counter, ratio register and tick detection.
// Ports:
//   clk_in, rst : clock and synchronous active-high reset
//   ptick       : parent tick (advances the counter)
//   ld          : load ld_ratio into the ratio register this edge
//   ld_ratio    : ratio value to load
//   tick        : combinational tick, high on the last parent tick of a period
module clk_div_stage #(
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = clk_div_pkg::DEFAULT_RATIO
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               ptick,
  input  logic               ld,
  input  logic [RATIO_W-1:0] ld_ratio,
  output logic               tick
);
  import clk_div_pkg::*;

  logic [RATIO_W-1:0] cnt;
  logic [RATIO_W-1:0] ratio;

  // The tick uses the ratio in force this cycle; a load on the same edge
  // only affects the following period.
  assign tick = ptick && (int'(cnt) == r_eff(int'(ratio)) - 1);

  always_ff @(posedge clk_in) begin
    if (rst) begin
      cnt   <= '0;
      ratio <= RATIO_W'(DEFAULT_RATIO);
    end else begin
      if (ptick) begin
        cnt <= tick ? '0 : cnt + RATIO_W'(1);
      end
      if (ld) begin
        ratio <= ld_ratio;
      end
    end
  end

endmodule

// File: rtl/clk_div_sequencer.sv
// Run/stop sequencer for a cascade of NUM_STAGES clock-divider stages.
// Ports:
//   clk_in, rst : clock and synchronous active-high reset
//   run         : level request, 1 = run, 0 = stop at a cascade boundary
//   cfg_valid/cfg_ready/cfg_stage/cfg_ratio : ratio reconfiguration handshake
//   cfg_err     : one-cycle pulse after an accepted out-of-range cfg_stage
//   stage_en    : per-stage one-cycle enable pulse (tick delayed one cycle)
//   idle        : high while the cascade is stopped
module clk_div_sequencer #(
  parameter int NUM_STAGES    = 3,
  parameter int RATIO_W       = 8,
  parameter int DEFAULT_RATIO = clk_div_pkg::DEFAULT_RATIO,
  parameter int STAGE_W       = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [STAGE_W-1:0]    cfg_stage,
  input  logic [RATIO_W-1:0]    cfg_ratio,
  output logic                  cfg_err,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  idle
);
  import clk_div_pkg::*;

  state_t                  state;
  state_t                  state_nxt;
  logic [NUM_STAGES-1:0]   ptick;
  logic [NUM_STAGES-1:0]   tick;
  logic [NUM_STAGES-1:0]   ld;
  logic [RATIO_W-1:0]      ld_ratio;
  logic                    pend_vld;
  logic [STAGE_W-1:0]      pend_stage;
  logic [RATIO_W-1:0]      pend_ratio;
  logic                    accept;
  logic                    stage_ok;
  logic                    idle_wr;
  logic                    pend_take;
  logic                    apply;

  assign cfg_ready = !pend_vld;
  assign idle      = (state == IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign stage_ok  = int'(cfg_stage) < NUM_STAGES;
  assign idle_wr   = accept && stage_ok && (state == IDLE);
  assign pend_take = accept && stage_ok && (state != IDLE);
  assign apply     = pend_vld && (|ld);

  // A tick of the last stage means every counter wraps on this edge, so
  // leaving DRAIN here lands in IDLE with all counters at 0.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (run) state_nxt = RUN;
      RUN:     if (!run) state_nxt = DRAIN;
      DRAIN: begin
        if (run)                         state_nxt = RUN;
        else if (tick[NUM_STAGES-1])     state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ratio loads: direct write while idle, otherwise the pending request is
  // applied at its stage's wrap or on entry to IDLE.
  always_comb begin
    ld       = '0;
    ld_ratio = pend_ratio;
    if (idle_wr) begin
      ld_ratio = cfg_ratio;
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (int'(cfg_stage) == k) ld[k] = 1'b1;
      end
    end else if (pend_vld) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if ((int'(pend_stage) == k) && (tick[k] || (state_nxt == IDLE))) ld[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= IDLE;
      pend_vld <= 1'b0;
      cfg_err  <= 1'b0;
      stage_en <= '0;
    end else begin
      state    <= state_nxt;
      stage_en <= tick;
      cfg_err  <= accept && !stage_ok;
      if (pend_take)  pend_vld <= 1'b1;
      else if (apply) pend_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (pend_take) begin
      pend_stage <= cfg_stage;
      pend_ratio <= cfg_ratio;
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_root
      assign ptick[k] = (state != IDLE);
    end else begin : g_chain
      assign ptick[k] = tick[k-1];
    end

    clk_div_stage #(
      .RATIO_W       (RATIO_W),
      .DEFAULT_RATIO (DEFAULT_RATIO)
    ) u_stage (
      .clk_in   (clk_in),
      .rst      (rst),
      .ptick    (ptick[k]),
      .ld       (ld[k]),
      .ld_ratio (ld_ratio),
      .tick     (tick[k])
    );
  end

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Directed bench for clk_div_sequencer (NUM_STAGES=3, RATIO_W=8).
module tb_clk_div_sequencer;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       run;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_stage;
  logic [7:0] cfg_ratio;
  logic       cfg_err;
  logic [2:0] stage_en;
  logic       idle;

  int passed = 0;
  int total  = 0;
  int s      = 0;

  clk_div_sequencer #(
    .NUM_STAGES (3),
    .RATIO_W    (8)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_stage (cfg_stage),
    .cfg_ratio (cfg_ratio),
    .cfg_err   (cfg_err),
    .stage_en  (stage_en),
    .idle      (idle)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
    s++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s at s=%0d: observed %0h expected %0h", tag, s, obs, exp);
    end
  endtask

  function automatic bit hit(input int t, input int p, input int o);
    return (t >= o) && (((t - o) % p) == 0);
  endfunction

  // Step until s reaches upto, checking stage_en against pulse trains with
  // period pN whose first pulse is at sample oN after RUN entry.
  task automatic span(input int upto, input int p0, input int o0,
                      input int p1, input int o1, input int p2, input int o2);
    logic [2:0] e;
    while (s < upto) begin
      step();
      e = {hit(s, p2, o2), hit(s, p1, o1), hit(s, p0, o0)};
      chk("stage_en", 32'(stage_en), 32'(e));
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_stage = '0; cfg_ratio = '0;
    step();
    step();
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_en", 32'(stage_en), 32'd0);
    chk("rst_err", 32'(cfg_err), 32'd0);

    // Default ratios 2/2/2, then stop at an arbitrary point
    rst = 1'b0; run = 1'b1;
    step(); s = 0;
    chk("run_entry_idle", 32'(idle), 32'd0);
    span(19, 2, 2, 4, 4, 8, 8);
    run = 1'b0;
    span(23, 2, 2, 4, 4, 8, 8);
    chk("drain_idle", 32'(idle), 32'd0);
    span(24, 2, 2, 4, 4, 8, 8);
    chk("drain_done_idle", 32'(idle), 32'd1);
    step();
    chk("idle_en", 32'(stage_en), 32'd0);

    // Idle write: stage1 ratio 3
    cfg_valid = 1'b1; cfg_stage = 2'd1; cfg_ratio = 8'd3;
    step();
    chk("idle_wr_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0; run = 1'b1;
    step(); s = 0;
    span(24, 2, 2, 6, 6, 12, 12);

    // Reset mid-run
    rst = 1'b1; run = 1'b0;
    step();
    chk("rst_run_idle", 32'(idle), 32'd1);
    chk("rst_run_en", 32'(stage_en), 32'd0);
    rst = 1'b0;

    // Idle write: stage0 ratio 0 -> pass-through
    cfg_valid = 1'b1; cfg_stage = 2'd0; cfg_ratio = 8'd0;
    step();
    cfg_valid = 1'b0; run = 1'b1;
    step(); s = 0;
    span(8, 1, 1, 2, 2, 4, 4);

    // Back to defaults, then stage2 ratio 4 written mid-period
    rst = 1'b1; run = 1'b0;
    step();
    rst = 1'b0; run = 1'b1;
    step(); s = 0;
    span(3, 2, 2, 4, 4, 16, 8);
    cfg_valid = 1'b1; cfg_stage = 2'd2; cfg_ratio = 8'd4;
    span(4, 2, 2, 4, 4, 16, 8);
    chk("pend_ready_lo", 32'(cfg_ready), 32'd0);
    cfg_valid = 1'b0;
    span(7, 2, 2, 4, 4, 16, 8);
    chk("pend_ready_hold", 32'(cfg_ready), 32'd0);
    span(8, 2, 2, 4, 4, 16, 8);
    chk("pend_ready_back", 32'(cfg_ready), 32'd1);
    span(26, 2, 2, 4, 4, 16, 8);

    // Drop and re-raise run within DRAIN: cadence must not break
    run = 1'b0;
    span(29, 2, 2, 4, 4, 16, 8);
    chk("drain_not_idle", 32'(idle), 32'd0);
    run = 1'b1;
    span(40, 2, 2, 4, 4, 16, 8);
    chk("rerun_idle", 32'(idle), 32'd0);

    // Out-of-range stage
    cfg_valid = 1'b1; cfg_stage = 2'd3; cfg_ratio = 8'd5;
    span(41, 2, 2, 4, 4, 16, 8);
    chk("err_pulse", 32'(cfg_err), 32'd1);
    chk("err_ready", 32'(cfg_ready), 32'd1);
    cfg_valid = 1'b0;
    span(42, 2, 2, 4, 4, 16, 8);
    chk("err_clear", 32'(cfg_err), 32'd0);
    span(56, 2, 2, 4, 4, 16, 8);

    // Reset in DRAIN with a pending request
    run = 1'b0; cfg_valid = 1'b1; cfg_stage = 2'd0; cfg_ratio = 8'd7;
    span(57, 2, 2, 4, 4, 16, 8);
    chk("drain_pend_ready", 32'(cfg_ready), 32'd0);
    chk("drain_pend_idle", 32'(idle), 32'd0);
    cfg_valid = 1'b0; rst = 1'b1;
    step();
    chk("rst_drain_idle", 32'(idle), 32'd1);
    chk("rst_drain_ready", 32'(cfg_ready), 32'd1);
    chk("rst_drain_en", 32'(stage_en), 32'd0);
    chk("rst_drain_err", 32'(cfg_err), 32'd0);
    rst = 1'b0; run = 1'b1;
    step(); s = 0;
    span(16, 2, 2, 4, 4, 8, 8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
